// File: rtl/tdc_multichannel.sv
// Multi-channel time-to-digital converter.
// Pulses are synchronised and rising edges detected per channel. The clk-cycle interval
// between consecutive events is measured. Each measurement is queued as a record
// {interval, start_mask, end_mask, coinc} in a small FIFO with a two-write, one-read port.
// The FIFO head is presented first-word-fall-through.
module tdc_multichannel #(
  parameter int N_CH  = 2,
  parameter int CNT_W = 6,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [N_CH-1:0]  pulse,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_interval,
  output logic [N_CH-1:0]  out_start,
  output logic [N_CH-1:0]  out_end,
  output logic             out_coinc,
  output logic             overflow,
  output logic [15:0]      drop_cnt
);

  localparam logic [CNT_W-1:0] MAX_CNT = '1;
  localparam int REC_W = CNT_W + 2 * N_CH + 1;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;

  // Synchroniser / edge detector state
  logic [N_CH-1:0][2:0] sync_q, sync_d;
  logic [N_CH-1:0]      edge_q, edge_d;

  // Measurement state
  logic [CNT_W-1:0]     count_q, count_d;
  logic [N_CH-1:0]      last_mask_q, last_mask_d;

  // FIFO state
  logic [REC_W-1:0]     mem_q [DEPTH];
  logic [REC_W-1:0]     mem_d [DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        fifo_cnt_q, fifo_cnt_d;
  logic                 overflow_q, overflow_d;
  logic [15:0]          drop_cnt_q, drop_cnt_d;

  // Event decode helpers
  logic                 ev;
  logic [7:0]           k_sum;
  logic [REC_W-1:0]     rec_a, rec_b;
  logic [1:0]           n_push, n_acc, n_drop;
  logic                 pop;
  logic [CW-1:0]        free_slots;
  logic [16:0]          drop_sum;
  logic [REC_W-1:0]     head;

  // Shift each pulse through three flops; an edge is a 0 -> 1 step in the two oldest samples
  always_comb begin
    sync_d = '0;
    edge_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      sync_d[i] = {sync_q[i][1:0], pulse[i]};
      edge_d[i] = (sync_q[i][2:1] == 2'b01);
    end
  end

  // Interval counter, record formation and FIFO bookkeeping
  always_comb begin
    ev = enable && (|edge_q);

    k_sum = '0;
    for (int i = 0; i < N_CH; i++) begin
      k_sum = k_sum + 8'(edge_q[i]);
    end

    // Counter restarts at 1 on an event and saturates at MAX_CNT (= no open start)
    count_d     = count_q;
    last_mask_d = last_mask_q;
    if (!enable) begin
      count_d     = MAX_CNT;
      last_mask_d = '0;
    end else if (ev) begin
      count_d     = CNT_W'(1);
      last_mask_d = edge_q;
    end else if (count_q < MAX_CNT) begin
      count_d     = count_q + CNT_W'(1);
    end

    // Records in write order; a coincidence with an open start emits the interval first
    rec_a  = '0;
    rec_b  = '0;
    n_push = 2'd0;
    if (ev) begin
      if (k_sum >= 8'd2) begin
        if (count_q < MAX_CNT) begin
          rec_a  = {count_q, last_mask_q, edge_q, 1'b1};
          rec_b  = {{CNT_W{1'b0}}, {N_CH{1'b0}}, edge_q, 1'b1};
          n_push = 2'd2;
        end else begin
          rec_a  = {{CNT_W{1'b0}}, {N_CH{1'b0}}, edge_q, 1'b1};
          n_push = 2'd1;
        end
      end else if (count_q < MAX_CNT) begin
        rec_a  = {count_q, last_mask_q, edge_q, 1'b0};
        n_push = 2'd1;
      end
    end

    // A pop in the same cycle frees a slot the pushes may use
    pop        = (fifo_cnt_q != '0) && out_ready;
    free_slots = CW'(DEPTH) - fifo_cnt_q + CW'(pop);
    if (CW'(n_push) <= free_slots) begin
      n_acc = n_push;
    end else begin
      n_acc = free_slots[1:0];
    end
    n_drop = n_push - n_acc;

    mem_d = mem_q;
    if (n_acc >= 2'd1) begin
      mem_d[wr_ptr_q] = rec_a;
    end
    if (n_acc == 2'd2) begin
      mem_d[wr_ptr_q + AW'(1)] = rec_b;
    end

    wr_ptr_d   = wr_ptr_q + AW'(n_acc);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    fifo_cnt_d = fifo_cnt_q + CW'(n_acc) - CW'(pop);

    // Dropped records are sticky in overflow and counted with saturation
    overflow_d = overflow_q | (n_drop != 2'd0);
    drop_sum   = {1'b0, drop_cnt_q} + 17'(n_drop);
    drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  // State registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q      <= '0;
      edge_q      <= '0;
      count_q     <= MAX_CNT;
      last_mask_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
      overflow_q  <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      sync_q      <= sync_d;
      edge_q      <= edge_d;
      count_q     <= count_d;
      last_mask_q <= last_mask_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fifo_cnt_q  <= fifo_cnt_d;
      overflow_q  <= overflow_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  // Head record falls through; fields read as zero while the FIFO is empty
  always_comb begin
    out_valid = (fifo_cnt_q != '0);
    head      = out_valid ? mem_q[rd_ptr_q] : '0;
  end

  assign {out_interval, out_start, out_end, out_coinc} = head;
  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

endmodule
